// File: rtl/joy_serializer_pkg.sv
// Shared joystick chain definitions: button indices, frame size and frame ordering.
// Used by joy_serializer and the matching host-side decoder.
package joy_serializer_pkg;

  localparam int JOY_BIT_UP    = 0;
  localparam int JOY_BIT_DOWN  = 1;
  localparam int JOY_BIT_LEFT  = 2;
  localparam int JOY_BIT_RIGHT = 3;
  localparam int JOY_BIT_FIRE1 = 4;
  localparam int JOY_BIT_FIRE2 = 5;
  localparam int JOY_BIT_FIRE3 = 6;
  localparam int JOY_BIT_START = 7;

  localparam int JOY_PORT_BITS  = 8;
  localparam int JOY_FRAME_BITS = 16;

  // Port 1 occupies the high byte so its start button is the first bit on the wire.
  localparam int JOY1_FRAME_LSB = 8;
  localparam int JOY2_FRAME_LSB = 0;

  typedef enum logic {
    MODE_SHIFT = 1'b0,
    MODE_LOAD  = 1'b1
  } joy_mode_e;

  function automatic logic [JOY_FRAME_BITS-1:0] joy_pack_frame(
    input logic [JOY_PORT_BITS-1:0] joy1,
    input logic [JOY_PORT_BITS-1:0] joy2
  );
    logic [JOY_FRAME_BITS-1:0] frame;
    frame = {JOY_FRAME_BITS{1'b1}};
    frame[JOY1_FRAME_LSB +: JOY_PORT_BITS] = joy1;
    frame[JOY2_FRAME_LSB +: JOY_PORT_BITS] = joy2;
    return frame;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Single-bit button debouncer: 2-flop synchronizer followed by a stability counter.
// Instantiated by joy_serializer only when JOY_SERIALIZER_DEBOUNCE_EN is defined.
module joy_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; flip once enough agree.
  always_comb begin
    state_d = state_q;
    cnt_d   = {CW{1'b0}};
    if (sync_q[1] != state_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        state_d = sync_q[1];
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= 1'b1;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync_q  <= {sync_q[0], din_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_o = state_q;

endmodule

// File: rtl/joy_serializer.sv
// 74HC165-style joystick serializer driven by oversampled host joy_load_n / joy_clk strobes.
// Optional input debounce is enabled with the JOY_SERIALIZER_DEBOUNCE_EN macro.
module joy_serializer
  import joy_serializer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int FRAME_BITS      = JOY_FRAME_BITS,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] joy1_n,
  input  logic [7:0] joy2_n,
  input  logic       joy_clk,
  input  logic       joy_load_n,
  output logic       joy_data,
  output logic       frame_done,
  output logic [4:0] bit_count
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

  logic [JOY_FRAME_BITS-1:0] buttons_s;

`ifdef JOY_SERIALIZER_DEBOUNCE_EN
  logic [JOY_FRAME_BITS-1:0] raw_s;
  assign raw_s = joy_pack_frame(joy1_n, joy2_n);

  for (genvar g = 0; g < JOY_FRAME_BITS; g++) begin : g_deb
    joy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .din_i  (raw_s[g]),
      .dout_o (buttons_s[g])
    );
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^32'(DEBOUNCE_CYCLES);
  assign buttons_s    = joy_pack_frame(joy1_n, joy2_n);
`endif

  logic [SYNC_STAGES-1:0] clk_sync_q, load_sync_q;
  logic                   clk_prev_q;
  logic                   clk_rise_s;
  joy_mode_e              mode_s;

  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [4:0]             count_q, count_d;
  logic                   done_q, done_d;
  logic                   data_q;

  assign clk_rise_s = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign mode_s     = load_sync_q[SYNC_STAGES-1] ? MODE_SHIFT : MODE_LOAD;

  // Load is level-sensitive and dominates any coincident joy_clk edge.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (mode_s)
      MODE_LOAD: begin
        shift_d = {FRAME_BITS{1'b1}};
        shift_d[FRAME_BITS-1 -: JOY_FRAME_BITS] = buttons_s;
        count_d = 5'd0;
      end
      MODE_SHIFT: begin
        if (clk_rise_s) begin
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b1};
          if (count_q == FRAME_CNT) begin
            count_d = count_q;
          end else begin
            count_d = count_q + 5'd1;
          end
          done_d = (count_q == FRAME_CNT - 5'd1);
        end else begin
          shift_d = shift_q;
        end
      end
      default: begin
        shift_d = {FRAME_BITS{1'b1}};
        count_d = 5'd0;
      end
    endcase
  end

  // joy_data is taken from the next shift value so pin-to-data latency is SYNC_STAGES+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= {SYNC_STAGES{1'b1}};
      load_sync_q <= {SYNC_STAGES{1'b1}};
      clk_prev_q  <= 1'b1;
      shift_q     <= {FRAME_BITS{1'b1}};
      count_q     <= 5'd0;
      done_q      <= 1'b0;
      data_q      <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], joy_load_n};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      shift_q     <= shift_d;
      count_q     <= count_d;
      done_q      <= done_d;
      data_q      <= shift_d[FRAME_BITS-1];
    end
  end

  assign joy_data   = data_q;
  assign frame_done = done_q;
  assign bit_count  = count_q;

endmodule

// File: tb/tb_joy_serializer.sv
// Directed scoreboard bench for joy_serializer; debounce steps run when JOY_SERIALIZER_DEBOUNCE_EN is defined.
module tb_joy_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] joy1_n = 8'hFF;
  logic [7:0] joy2_n = 8'hFF;
  logic       joy_clk = 1'b1;
  logic       joy_load_n = 1'b1;
  logic       joy_data;
  logic       frame_done;
  logic [4:0] bit_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int fd_count = 0;
  int fd_exp   = 0;
  logic sb_q[$];

  joy_serializer #(
    .SYNC_STAGES(2),
    .FRAME_BITS(16),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .joy1_n     (joy1_n),
    .joy2_n     (joy2_n),
    .joy_clk    (joy_clk),
    .joy_load_n (joy_load_n),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) sb_q.push_back(w[i]);
  endtask

  task automatic sample_bit(input string tag);
    logic e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed scoreboard empty expected queued bit", tag);
    end else begin
      e = sb_q.pop_front();
      check(tag, {15'd0, joy_data}, {15'd0, e});
    end
  endtask

  task automatic clk_edge();
    joy_clk = 1'b0;
    wait_cyc(4);
    joy_clk = 1'b1;
    wait_cyc(4);
  endtask

  task automatic load_pulse();
    joy_load_n = 1'b0;
    wait_cyc(4);
    joy_load_n = 1'b1;
    wait_cyc(4);
  endtask

  task automatic set_buttons(input logic [7:0] j1, input logic [7:0] j2);
    joy1_n = j1;
    joy2_n = j2;
    wait_cyc(40);
  endtask

  task automatic read_bits(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      sample_bit(tag);
      clk_edge();
    end
  endtask

  initial begin
    // Reset held while the host clock keeps running.
    for (int i = 0; i < 3; i++) clk_edge();
    check("rst_data_held", {15'd0, joy_data}, 16'd1);
    check("rst_count_held", {11'd0, bit_count}, 16'd0);
    rst = 1'b0;
    wait_cyc(4);
    check("rst_data", {15'd0, joy_data}, 16'd1);
    check("rst_count", {11'd0, bit_count}, 16'd0);
    check("rst_no_done", 16'(fd_count), 16'(fd_exp));

    // Without a load the chain reads all ones.
    for (int i = 0; i < 2; i++) clk_edge();
    check("preload_data", {15'd0, joy_data}, 16'd1);
    check("preload_count", {11'd0, bit_count}, 16'd2);

    // Full frame: fire1+up on port 1, start on port 2.
    set_buttons(8'b1110_1110, 8'b0111_1111);
    load_pulse();
    check("frame_count0", {11'd0, bit_count}, 16'd0);
    push_word(16'hEE7F);
    read_bits("frame_bit", 16);
    fd_exp++;
    check("frame_done_cnt", 16'(fd_count), 16'(fd_exp));
    check("frame_count16", {11'd0, bit_count}, 16'd16);

    // Overclocking past the frame.
    for (int i = 0; i < 4; i++) begin
      clk_edge();
      sb_q.push_back(1'b1);
      sample_bit("over_data");
    end
    check("over_count", {11'd0, bit_count}, 16'd16);
    check("over_no_done", 16'(fd_count), 16'(fd_exp));

    // Load released mid-frame restarts with a fresh snapshot.
    load_pulse();
    push_word(16'hEE7F);
    read_bits("mid_bit", 5);
    check("mid_count5", {11'd0, bit_count}, 16'd5);
    sb_q.delete();
    set_buttons(8'h7F, 8'h7F);
    joy_load_n = 1'b0;
    wait_cyc(4);
    check("mid_load_count", {11'd0, bit_count}, 16'd0);
    check("mid_load_data", {15'd0, joy_data}, 16'd0);
    joy_load_n = 1'b1;
    wait_cyc(4);
    push_word(16'h7F7F);
    read_bits("mid_new_bit", 16);
    fd_exp++;
    check("mid_done_cnt", 16'(fd_count), 16'(fd_exp));

    // Clock edge and load arrive in the same synchronized cycle.
    load_pulse();
    for (int i = 0; i < 3; i++) clk_edge();
    set_buttons(8'h6A, 8'hC3);
    joy_clk = 1'b0;
    wait_cyc(4);
    joy_clk    = 1'b1;
    joy_load_n = 1'b0;
    wait_cyc(4);
    check("coll_count", {11'd0, bit_count}, 16'd0);
    check("coll_data", {15'd0, joy_data}, 16'd0);
    joy_load_n = 1'b1;
    wait_cyc(4);
    check("coll_count_rel", {11'd0, bit_count}, 16'd0);
    push_word(16'h6AC3);
    read_bits("coll_bit", 16);
    fd_exp++;
    check("coll_done_cnt", 16'(fd_count), 16'(fd_exp));

    // Reset asserted mid-frame.
    set_buttons(8'hEE, 8'h7F);
    load_pulse();
    for (int i = 0; i < 3; i++) clk_edge();
    check("midrst_pre_data", {15'd0, joy_data}, 16'd0);
    rst = 1'b1;
    #1;
    check("midrst_data", {15'd0, joy_data}, 16'd1);
    check("midrst_count", {11'd0, bit_count}, 16'd0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(2);
    clk_edge();
    check("postrst_data", {15'd0, joy_data}, 16'd1);
    check("postrst_count", {11'd0, bit_count}, 16'd1);
    check("postrst_done", 16'(fd_count), 16'(fd_exp));

`ifdef JOY_SERIALIZER_DEBOUNCE_EN
    // Short glitch is filtered, a sustained press is accepted.
    set_buttons(8'hFF, 8'hFF);
    joy1_n[0] = 1'b0;
    wait_cyc(10);
    joy1_n[0] = 1'b1;
    wait_cyc(10);
    load_pulse();
    push_word(16'hFFFF);
    read_bits("deb_glitch", 16);
    fd_exp++;
    joy1_n[0] = 1'b0;
    wait_cyc(20);
    load_pulse();
    push_word(16'hFEFF);
    read_bits("deb_press", 16);
    fd_exp++;
    check("deb_done_cnt", 16'(fd_count), 16'(fd_exp));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/joy_serializer.md
Name: joy_serializer

Overview:
- Device-side end of the board's serial joystick chain; emulates the 74HC165-style parallel-in/serial-out chain that the joystick decoder reads.
- Captures two DB9 joystick ports in parallel and shifts them out on joy_data, clocked by the host's joy_load_n and joy_clk.
- Runs on the system clock. Host strobes are oversampled and synchronized, not used as clocks.
- Used in the joystick adapter build and as the bench partner for the decoder.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on joy_clk and joy_load_n (minimum 2).
- FRAME_BITS, 16, bits per frame: 8 per joystick.
- DEBOUNCE_CYCLES, 1024, stable-sample count needed before a button input is accepted. Used only with the optional feature.

Ports:
- clk, input, 1: system clock. Must be at least 8× the host joy_clk rate.
- rst, input, 1: asynchronous, active-high reset.
- joy1_n, input, 8: port 1 buttons, active-low, ordered {start,fire3,fire2,fire1,right,left,down,up}, bit7..bit0.
- joy2_n, input, 8: port 2 buttons, same ordering.
- joy_clk, input, 1: host shift clock. Asynchronous to clk.
- joy_load_n, input, 1: host parallel-load strobe, active-low, level-sensitive. Asynchronous to clk.
- joy_data, output, 1: serial data to host.
- frame_done, output, 1: one-cycle pulse when bit FRAME_BITS-1 has been shifted out.
- bit_count, output, 5: number of shifts since the last load, saturating at FRAME_BITS.

Behaviour:
- Reset:
  - shift register is all ones; joy_data = 1; bit_count = 0; frame_done = 0.
  - Synchronizer flops reset to 1 (load inactive, clock high).
- Synchronization: joy_clk and joy_load_n each pass through SYNC_STAGES flops. A rising edge of joy_clk is detected as sync=1 while the previous sample = 0.
- Frame layout: shift word = {joy1_n, joy2_n}. Bit 15 = joy1 start, bit 0 = joy2 up.
- LOAD state (synced load_n = 0):
  - Shift register reloads every clk cycle from the current button inputs, transparent like a '165.
  - bit_count = 0.
  - joy_clk edges are ignored.
- SHIFT state (synced load_n = 1):
  - On each detected joy_clk rising edge: shift register shifts left and fills bit 0 with 1 (unpressed); bit_count increments.
  - When bit_count reaches FRAME_BITS, it saturates. Further edges still shift, so joy_data stays 1.
  - frame_done pulses for one cycle on the edge that moves bit_count from FRAME_BITS-1 to FRAME_BITS.
- joy_data = shift register bit 15, registered.
- Latency:
  - joy_clk rising edge at pin to new joy_data: SYNC_STAGES+1 clk cycles.
  - joy_load_n falling edge to joy_data showing joy1 start: SYNC_STAGES+1 clk cycles.
- Simultaneous events: a clock edge detected in the same cycle that synced load_n goes low is discarded; load wins.
- Load released mid-frame: the next frame restarts at bit 15 with a fresh snapshot.
- Reset asserted mid-frame: everything returns immediately to reset values. The first frame after reset reads all ones until a load occurs.

Optional Feature:
- Macro: JOY_SERIALIZER_DEBOUNCE_EN.
- With the macro defined:
  - Each of the 16 button inputs passes through a 2-flop synchronizer, then a per-bit counter.
  - A new level is accepted only after DEBOUNCE_CYCLES consecutive equal samples.
  - The load path uses the debounced vector.
  - Debounced state resets to all ones.
- Without the macro: raw inputs feed the load path directly, with no debounce logic and no extra latency.

Decomposition:
- Shared package holds:
  - JOY_BIT_UP/DOWN/LEFT/RIGHT/FIRE1/FIRE2/FIRE3/START index constants (0..7);
  - FRAME_BITS default;
  - the frame-ordering constant so that decoder and serializer agree.
- Natural sub-module: joy_debounce. It is single-bit and parameterized by DEBOUNCE_CYCLES, and is instantiated 16 times only under JOY_SERIALIZER_DEBOUNCE_EN.
- Synchronizer and edge detect stay inline.

Test Plan:
- Reset: assert rst with joy_clk toggling, release -> joy_data=1, bit_count=0, frame_done never pulses; after a load, normal frame.
- Full frame: joy1_n=8'b1110_1110 (fire1 and up pressed), joy2_n=8'b0111_1111 (start pressed); pulse load_n low for 4 cycles, then 16 joy_clk edges -> sampled serial stream 16'hEE7F MSB-first; frame_done pulses once after edge 16; bit_count=16.
- Overclocking: 4 extra joy_clk edges after a full frame -> joy_data=1 on each; bit_count stays 16; no extra frame_done.
- Load mid-frame: after 5 edges, pulse load with joy1_n changed to 8'h7F -> next read starts at bit 15 = 0; bit_count=0.
- Load/clock collision: joy_clk rising edge and load_n falling edge arrive in the same synced cycle -> no shift; joy_data = new bit 15.
- Debounce (macro defined, DEBOUNCE_CYCLES=16): 10-cycle glitch on joy1 up -> loaded word unchanged; a 20-cycle low -> bit 8 of the loaded frame reads 0.
